pkt_rx_intf: RTL and testbench
==============================

PKT_RX_INTF -- requirements
Module: pkt_rx_intf

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all state changes on rising clk_156m25.
REQ-002 Ports:
- clk_156m25 in 1: clock.
- reset_156m25_n in 1: async active-low reset.
- rx_en in 1: enables starting new packet reads.
- clr_stats in 1: synchronous clear of all counters.
- pkt_rx_avail in 1: MAC has a packet queued.
- pkt_rx_data in 64: MAC word.
- pkt_rx_val in 1: word valid.
- pkt_rx_sop in 1: start of packet.
- pkt_rx_eop in 1: end of packet.
- pkt_rx_mod in 3: valid bytes on the EOP word (0 = 8).
- pkt_rx_err in 1: packet error, qualified with val & eop.
- pkt_rx_ren out 1: read enable to the MAC.
- out_data out 64, out_val out 1, out_sop out 1, out_eop out 1, out_mod out 3, out_err out 1: registered word stream.
- good_pkt_cnt out 32, err_pkt_cnt out 32, byte_cnt out 32, frame_err_cnt out 16: statistics.
- busy out 1: high in state READ.

Function
REQ-003 SHALL implement states IDLE and READ.
REQ-004 IDLE -> READ when rx_en=1 and pkt_rx_avail=1 at a clock edge.
REQ-005 READ -> IDLE on the edge where pkt_rx_val=1 and pkt_rx_eop=1.
REQ-006 pkt_rx_ren SHALL equal (state==READ) AND NOT (pkt_rx_val AND pkt_rx_eop), combinationally, so ren drops in the EOP cycle.
REQ-007 Deasserting rx_en in READ SHALL NOT abort the current packet; it only blocks the next IDLE -> READ.
REQ-008 An in_pkt flag SHALL be set by a valid SOP and cleared by a valid EOP; a word with both SOP and EOP is a one-word packet.
REQ-009 Each accepted word (val=1, framing legal) SHALL appear on out_* one cycle later with out_val=1; out_val=0 otherwise.
REQ-010 A valid word with sop=0 while in_pkt=0 SHALL be dropped and increment frame_err_cnt.
REQ-011 A valid SOP while in_pkt=1 SHALL increment frame_err_cnt, discard the partial packet from statistics (no pkt/byte counting), and start a new packet with this word.
REQ-012 Bytes per accepted word: 8 for non-EOP; for EOP, mod==0 -> 8, else mod; packet byte total accumulates in an internal 32-bit register.
REQ-013 On valid EOP with pkt_rx_err=0: good_pkt_cnt +1, byte_cnt += packet total; with err=1: err_pkt_cnt +1, byte_cnt unchanged; out_err mirrors err on that word.
REQ-014 All counters SHALL saturate at all-ones.
REQ-015 clr_stats=1 SHALL zero all counters that edge; it has priority over a same-cycle increment and does not affect state, in_pkt, or out_*.
REQ-016 Valid words while in IDLE, which a compliant MAC does not produce, SHALL still be processed by REQ-008 to REQ-013.

Reset
REQ-017 While reset_156m25_n=0: state=IDLE, in_pkt=0, packet byte total=0, pkt_rx_ren=0, busy=0, out_* = 0, all counters = 0.
REQ-018 Reset asserted mid-packet SHALL discard the packet without counting it; after release, the next word must be a SOP.

Verification
REQ-019 Reset and idle: hold reset 20 ns, then avail=0 -> ren=0, all counters 0, out_val=0.
REQ-020 Three-word packet: avail=1, rx_en=1 -> ren=1 the next cycle; words SOP, mid, EOP with mod=4, err=0 -> ren low in the EOP cycle, good_pkt_cnt=1, byte_cnt=20, out_* shows 3 words at +1 cycle latency.
REQ-021 Errored one-word packet: SOP+EOP, mod=0, err=1 -> err_pkt_cnt=1, byte_cnt unchanged, out_err=1.
REQ-022 Framing: val without SOP in IDLE, then SOP, SOP, EOP (mod=0) -> frame_err_cnt=2, good_pkt_cnt=1, byte_cnt=16.
REQ-023 Reset asserted after SOP, released, then clean 2-word packet (mod=0) -> good_pkt_cnt=1, byte_cnt=16, frame_err_cnt=0.
REQ-024 clr_stats pulsed coincident with a good EOP -> all counters 0 on the next cycle; state returns to IDLE.

Source files
------------

// File: rtl/pkt_rx_if.sv
// MAC receive-side bus: packet-available flag, framed 64-bit word stream and the
// read enable returned to the MAC.
interface pkt_rx_if;
    logic        pkt_rx_avail;
    logic [63:0] pkt_rx_data;
    logic        pkt_rx_val;
    logic        pkt_rx_sop;
    logic        pkt_rx_eop;
    logic [2:0]  pkt_rx_mod;
    logic        pkt_rx_err;
    logic        pkt_rx_ren;

    modport master (
        output pkt_rx_avail, pkt_rx_data, pkt_rx_val, pkt_rx_sop,
        output pkt_rx_eop, pkt_rx_mod, pkt_rx_err,
        input  pkt_rx_ren
    );

    modport slave (
        input  pkt_rx_avail, pkt_rx_data, pkt_rx_val, pkt_rx_sop,
        input  pkt_rx_eop, pkt_rx_mod, pkt_rx_err,
        output pkt_rx_ren
    );
endinterface

// File: rtl/pkt_rx_intf.sv
// Packet receive front end: pulls packets from the MAC, checks SOP/EOP framing,
// forwards accepted words one cycle later and keeps saturating statistics.
module pkt_rx_intf (
    input  logic        clk_156m25,
    input  logic        reset_156m25_n,
    input  logic        rx_en,
    input  logic        clr_stats,
    pkt_rx_if.slave     mac,
    output logic [63:0] out_data,
    output logic        out_val,
    output logic        out_sop,
    output logic        out_eop,
    output logic [2:0]  out_mod,
    output logic        out_err,
    output logic [31:0] good_pkt_cnt,
    output logic [31:0] err_pkt_cnt,
    output logic [31:0] byte_cnt,
    output logic [15:0] frame_err_cnt,
    output logic        busy
);
    typedef enum logic {IDLE, READ} state_t;

    state_t      state_q, state_d;
    logic        in_pkt_q, in_pkt_d;
    logic [31:0] pkt_bytes_q, pkt_bytes_d;
    logic [31:0] good_q, good_d, err_q, err_d, bytes_q, bytes_d;
    logic [15:0] frame_err_q, frame_err_d;
    logic [63:0] out_data_q, out_data_d;
    logic        out_val_q, out_val_d, out_sop_q, out_sop_d;
    logic        out_eop_q, out_eop_d, out_err_q, out_err_d;
    logic [2:0]  out_mod_q, out_mod_d;

    logic        val_eop;
    logic        accept;
    logic        frame_err_inc;
    logic        good_inc;
    logic        err_inc;
    logic [31:0] word_bytes;
    logic [31:0] pkt_total;
    logic [32:0] byte_sum;

    assign val_eop = mac.pkt_rx_val & mac.pkt_rx_eop;

    // State register
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) state_q <= IDLE;
        else                 state_q <= state_d;
    end

    // Next state: dropping rx_en in READ only blocks the next packet, never aborts one
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rx_en && mac.pkt_rx_avail) state_d = READ;
            READ:    if (val_eop)                   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: ren falls combinationally in the EOP cycle
    always_comb begin
        mac.pkt_rx_ren = (state_q == READ) && !val_eop;
        busy           = (state_q == READ);
    end

    // Framing, packet byte accumulation and statistics
    always_comb begin
        word_bytes    = (mac.pkt_rx_eop && mac.pkt_rx_mod != 3'd0) ? {29'd0, mac.pkt_rx_mod} : 32'd8;
        pkt_total     = (mac.pkt_rx_sop ? 32'd0 : pkt_bytes_q) + word_bytes;
        byte_sum      = {1'b0, bytes_q} + {1'b0, pkt_total};
        accept        = 1'b0;
        frame_err_inc = 1'b0;
        good_inc      = 1'b0;
        err_inc       = 1'b0;
        in_pkt_d      = in_pkt_q;
        pkt_bytes_d   = pkt_bytes_q;

        if (mac.pkt_rx_val) begin
            if (mac.pkt_rx_sop) begin
                // A SOP inside a packet abandons the partial one and restarts here
                accept        = 1'b1;
                frame_err_inc = in_pkt_q;
            end else if (in_pkt_q) begin
                accept = 1'b1;
            end else begin
                frame_err_inc = 1'b1;
            end
        end

        if (accept) begin
            if (mac.pkt_rx_eop) begin
                in_pkt_d    = 1'b0;
                pkt_bytes_d = 32'd0;
                err_inc     = mac.pkt_rx_err;
                good_inc    = !mac.pkt_rx_err;
            end else begin
                in_pkt_d    = 1'b1;
                pkt_bytes_d = pkt_total;
            end
        end

        good_d      = (good_inc && good_q != '1) ? good_q + 32'd1 : good_q;
        err_d       = (err_inc && err_q != '1) ? err_q + 32'd1 : err_q;
        frame_err_d = (frame_err_inc && frame_err_q != '1) ? frame_err_q + 16'd1 : frame_err_q;
        bytes_d     = !good_inc ? bytes_q : (byte_sum[32] ? '1 : byte_sum[31:0]);

        if (clr_stats) begin
            good_d      = '0;
            err_d       = '0;
            frame_err_d = '0;
            bytes_d     = '0;
        end

        out_val_d  = accept;
        out_data_d = accept ? mac.pkt_rx_data : 64'd0;
        out_sop_d  = accept && mac.pkt_rx_sop;
        out_eop_d  = accept && mac.pkt_rx_eop;
        out_mod_d  = accept ? mac.pkt_rx_mod : 3'd0;
        out_err_d  = accept && mac.pkt_rx_eop && mac.pkt_rx_err;
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            in_pkt_q    <= 1'b0;
            pkt_bytes_q <= '0;
            good_q      <= '0;
            err_q       <= '0;
            bytes_q     <= '0;
            frame_err_q <= '0;
            out_data_q  <= '0;
            out_val_q   <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_mod_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            in_pkt_q    <= in_pkt_d;
            pkt_bytes_q <= pkt_bytes_d;
            good_q      <= good_d;
            err_q       <= err_d;
            bytes_q     <= bytes_d;
            frame_err_q <= frame_err_d;
            out_data_q  <= out_data_d;
            out_val_q   <= out_val_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_mod_q   <= out_mod_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_data      = out_data_q;
    assign out_val       = out_val_q;
    assign out_sop       = out_sop_q;
    assign out_eop       = out_eop_q;
    assign out_mod       = out_mod_q;
    assign out_err       = out_err_q;
    assign good_pkt_cnt  = good_q;
    assign err_pkt_cnt   = err_q;
    assign byte_cnt      = bytes_q;
    assign frame_err_cnt = frame_err_q;
endmodule

// File: tb/tb_pkt_rx_intf.sv
// Directed scenarios plus randomized MAC traffic, checked cycle by cycle against
// a packet-level reference model.
module tb_pkt_rx_intf;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_en;
    logic        clr_stats;
    logic [63:0] out_data;
    logic        out_val, out_sop, out_eop, out_err, busy;
    logic [2:0]  out_mod;
    logic [31:0] good_pkt_cnt, err_pkt_cnt, byte_cnt;
    logic [15:0] frame_err_cnt;

    pkt_rx_if mac_if ();

    pkt_rx_intf dut (
        .clk_156m25     (clk),
        .reset_156m25_n (rst_n),
        .rx_en          (rx_en),
        .clr_stats      (clr_stats),
        .mac            (mac_if),
        .out_data       (out_data),
        .out_val        (out_val),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .out_mod        (out_mod),
        .out_err        (out_err),
        .good_pkt_cnt   (good_pkt_cnt),
        .err_pkt_cnt    (err_pkt_cnt),
        .byte_cnt       (byte_cnt),
        .frame_err_cnt  (frame_err_cnt),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a packet is the list of byte counts of its words
    bit          m_busy, m_in_pkt;
    int unsigned m_words[$];
    longint      m_good, m_err, m_bytes, m_fe;
    logic [63:0] e_data;
    bit          e_val, e_sop, e_eop, e_err;
    logic [2:0]  e_mod;
    localparam longint MAX32 = 64'hFFFF_FFFF;
    localparam longint MAX16 = 64'hFFFF;

    function automatic longint sat(input longint x, input longint mx);
        return (x > mx) ? mx : x;
    endfunction

    task automatic model_clear();
        m_busy = 0; m_in_pkt = 0; m_words.delete();
        m_good = 0; m_err = 0; m_bytes = 0; m_fe = 0;
        e_data = 0; e_val = 0; e_sop = 0; e_eop = 0; e_err = 0; e_mod = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".out_val"}, out_val, e_val);
        check_eq({tag, ".out_data"}, out_data, e_data);
        check_eq({tag, ".out_sop"}, out_sop, e_sop);
        check_eq({tag, ".out_eop"}, out_eop, e_eop);
        check_eq({tag, ".out_mod"}, out_mod, e_mod);
        check_eq({tag, ".out_err"}, out_err, e_err);
        check_eq({tag, ".good"}, good_pkt_cnt, m_good);
        check_eq({tag, ".errpkt"}, err_pkt_cnt, m_err);
        check_eq({tag, ".bytes"}, byte_cnt, m_bytes);
        check_eq({tag, ".frame_err"}, frame_err_cnt, m_fe);
    endtask

    // One clock of stimulus; entered and left at posedge+1
    task automatic cyc(input string tag, input bit v, s, e, input logic [2:0] m, input bit er,
                       input bit en, av, cl, input logic [63:0] d);
        bit          accepted;
        int unsigned total;
        mac_if.pkt_rx_val = v;  mac_if.pkt_rx_sop = s;  mac_if.pkt_rx_eop = e;
        mac_if.pkt_rx_mod = m;  mac_if.pkt_rx_err = er; mac_if.pkt_rx_data = d;
        mac_if.pkt_rx_avail = av; rx_en = en; clr_stats = cl;
        #1;
        check_eq({tag, ".ren"}, mac_if.pkt_rx_ren, m_busy && !(v && e));
        check_eq({tag, ".busy"}, busy, m_busy);

        if (!m_busy) m_busy = en && av;
        else if (v && e) m_busy = 0;
        accepted = 0;
        if (v) begin
            if (s) begin
                if (m_in_pkt) m_fe = sat(m_fe + 1, MAX16);
                m_words.delete();
                accepted = 1;
            end else if (m_in_pkt) accepted = 1;
            else m_fe = sat(m_fe + 1, MAX16);
        end
        if (accepted) begin
            m_words.push_back((e && m != 0) ? int'(m) : 8);
            if (e) begin
                total = 0;
                foreach (m_words[i]) total += m_words[i];
                if (er) m_err = sat(m_err + 1, MAX32);
                else begin
                    m_good  = sat(m_good + 1, MAX32);
                    m_bytes = sat(m_bytes + total, MAX32);
                end
                m_words.delete();
                m_in_pkt = 0;
            end else m_in_pkt = 1;
        end
        if (cl) begin m_good = 0; m_err = 0; m_bytes = 0; m_fe = 0; end
        e_val = accepted; e_data = accepted ? d : 64'd0;
        e_sop = accepted && s; e_eop = accepted && e;
        e_mod = accepted ? m : 3'd0; e_err = accepted && e && er;

        if (v) $display("%0t %s val sop=%0b eop=%0b mod=%0d err=%0b clr=%0b", $time, tag, s, e, m, er, cl);
        @(posedge clk); #1;
        check_outputs(tag);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        mac_if.pkt_rx_val = 0; mac_if.pkt_rx_sop = 0; mac_if.pkt_rx_eop = 0;
        mac_if.pkt_rx_mod = 0; mac_if.pkt_rx_err = 0; mac_if.pkt_rx_data = 0;
        mac_if.pkt_rx_avail = 0; rx_en = 0; clr_stats = 0;
        #20;
        model_clear();
        check_eq("rst.ren", mac_if.pkt_rx_ren, 0);
        check_eq("rst.busy", busy, 0);
        check_outputs("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("%0t reset released", $time);
    endtask

    initial begin
        model_clear();
        apply_reset();

        // Idle with no packet available
        cyc("idle", 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check_eq("idle.ren_low", mac_if.pkt_rx_ren, 0);

        // Three-word packet, mod=4
        cyc("avail", 0, 0, 0, 0, 0, 1, 1, 0, 0);
        check_eq("avail.busy", busy, 1);
        cyc("p3.sop", 1, 1, 0, 0, 0, 1, 1, 0, 64'h1111_0000_0000_0001);
        cyc("p3.mid", 1, 0, 0, 0, 0, 1, 1, 0, 64'h2222_0000_0000_0002);
        cyc("p3.eop", 1, 0, 1, 4, 0, 1, 1, 0, 64'h3333_0000_0000_0003);
        check_eq("p3.good_const", good_pkt_cnt, 1);
        check_eq("p3.bytes_const", byte_cnt, 20);
        check_eq("p3.busy_idle", busy, 0);

        // Errored one-word packet
        cyc("e1.avail", 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc("e1.word", 1, 1, 1, 0, 1, 1, 1, 0, 64'hDEAD_BEEF_0000_0001);
        check_eq("e1.err_const", err_pkt_cnt, 1);
        check_eq("e1.bytes_const", byte_cnt, 20);
        check_eq("e1.out_err_const", out_err, 1);

        // Framing errors: stray word, SOP, SOP, EOP
        cyc("fr.clr", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("fr.stray", 1, 0, 0, 0, 0, 0, 0, 0, 64'h5);
        cyc("fr.sop1", 1, 1, 0, 0, 0, 0, 0, 0, 64'h6);
        cyc("fr.sop2", 1, 1, 0, 0, 0, 0, 0, 0, 64'h7);
        cyc("fr.eop", 1, 0, 1, 0, 0, 0, 0, 0, 64'h8);
        check_eq("fr.fe_const", frame_err_cnt, 2);
        check_eq("fr.good_const", good_pkt_cnt, 1);
        check_eq("fr.bytes_const", byte_cnt, 16);

        // Reset in mid-packet, then a clean two-word packet
        cyc("rm.avail", 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc("rm.sop", 1, 1, 0, 0, 0, 1, 1, 0, 64'hA);
        apply_reset();
        cyc("rm.avail2", 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc("rm.sop2", 1, 1, 0, 0, 0, 1, 1, 0, 64'hB);
        cyc("rm.eop2", 1, 0, 1, 0, 0, 1, 1, 0, 64'hC);
        check_eq("rm.good_const", good_pkt_cnt, 1);
        check_eq("rm.bytes_const", byte_cnt, 16);
        check_eq("rm.fe_const", frame_err_cnt, 0);

        // clr_stats coincident with a good EOP
        cyc("cl.avail", 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc("cl.sop", 1, 1, 0, 0, 0, 1, 1, 0, 64'hD);
        cyc("cl.eop", 1, 0, 1, 3, 0, 1, 1, 1, 64'hE);
        check_eq("cl.good_const", good_pkt_cnt, 0);
        check_eq("cl.bytes_const", byte_cnt, 0);
        check_eq("cl.busy_const", busy, 0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            cyc("rnd",
                $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3,
                3'($urandom_range(0, 7)), $urandom_range(0, 4) == 0,
                $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0,
                {$urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
